pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit.
- Holds the architectural PC register and computes the sequential increment.
- Selects the next PC from trap, redirect (branch/jump), return-address prediction, stall-hold or sequential sources.
- Contains a small circular return-address stack (RAS) for call/return. It feeds the instruction-memory address and the link-value path of the datapath.

Parameters:
- XLEN, 32, width of PC and all address ports.
- INSTR_BYTES, 4, sequential increment in bytes; power of two, at least 2.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0004, PC loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC this cycle.
- redirect_i  input  1  take target_i (branch taken / jump).
- target_i  input  XLEN  redirect target address.
- call_i  input  1  redirect is a call; push link value; qualified by redirect_i.
- ret_i  input  1  redirect is a return; pop RAS; qualified by redirect_i.
- trap_i  input  1  exception; go to TRAP_VECTOR.
- pc_o  output  XLEN  current PC (registered).
- pc_plus_o  output  XLEN  pc_o + INSTR_BYTES (combinational link value).
- pc_next_o  output  XLEN  value pc_o takes at the next edge (combinational).
- ras_empty_o  output  1  RAS count == 0.
- ras_full_o  output  1  RAS count == RAS_DEPTH.
- ras_underflow_o  output  1  registered one-cycle pulse: ret_i taken with empty RAS.
- misaligned_o  output  1  registered one-cycle pulse: redirect target not INSTR_BYTES-aligned.

Behaviour:
- Reset, asynchronous while rst_n = 0:
  - pc_o = RESET_VECTOR.
  - RAS pointer = 0, count = 0, entries = 0.
  - ras_underflow_o = 0, misaligned_o = 0.
  - ras_empty_o = 1, ras_full_o = 0.
  - The first edge after deassertion performs a normal update.
- Arithmetic: pc_plus_o = pc_o + INSTR_BYTES modulo 2^XLEN. Wrap from all-ones region to 0 is legal and silent.
- Next-PC priority, highest first:
  1. trap_i: TRAP_VECTOR.
  2. redirect_i with misaligned target_i (low log2(INSTR_BYTES) bits nonzero): TRAP_VECTOR; misaligned_o pulses the next cycle. No RAS operation.
  3. redirect_i & ret_i & RAS non-empty: RAS top entry (target_i ignored).
  4. redirect_i & ret_i & RAS empty: target_i; ras_underflow_o pulses the next cycle.
  5. redirect_i otherwise: target_i.
  6. stall_i: pc_o (hold).
  7. Otherwise: pc_plus_o.
- Redirect and trap override stall. Stall suppresses only sequential advance.
- pc_next_o always equals the selected value. pc_o <= pc_next_o every edge.
- RAS operations occur only in case 3/4/5 cycles with call_i or ret_i set; never on trap or misaligned redirect.
- Push (call_i):
  - Writes pc_plus_o at the top; pointer increments modulo RAS_DEPTH.
  - If full: the oldest entry is overwritten and count stays RAS_DEPTH.
- Pop (ret_i):
  - Pointer decrements modulo RAS_DEPTH; count decrements.
  - When empty: no pointer or count change.
- call_i and ret_i both set (case 3): top entry is replaced with pc_plus_o; pointer and count unchanged. The return target is the old top.
- call_i and ret_i both set with empty RAS (case 4): push only (count becomes 1); ras_underflow_o still pulses.
- Pulses last exactly one cycle and never coincide with reset.
- Reset mid-operation discards all RAS contents.

Decomposition:
- Shared package pc_pkg:
  - next-PC source encoding enum: SRC_TRAP, SRC_MISALIGN, SRC_RAS, SRC_TARGET, SRC_HOLD, SRC_SEQ.
  - Default vector constants.
  - An alignment-check function.
- One sub-module, pc_ras: circular stack with push/pop/replace, count, empty/full. Parameters XLEN and RAS_DEPTH; same clk/rst_n.
- The top level holds the PC register, adder, priority mux and pulse registers.

Test Plan:
- Release rst_n, no controls for 3 edges -> pc_o = 0x0, 0x4, 0x8, 0xC. pc_plus_o = 0x10 at the end.
- Load PC via redirect to 0xFFFF_FFFC, then 1 free edge -> pc_o = 0x0000_0000 (wrap). Then stall_i high for 2 edges -> pc_o holds 0x0.
- At pc 0x100 assert redirect_i + call_i, target 0x400 -> pc_o = 0x400, RAS top = 0x104. Later redirect_i + ret_i, target 0xDEAD_0000 -> pc_o = 0x104, ras_empty_o = 1.
- Perform 5 calls with RAS_DEPTH = 4 -> ras_full_o = 1. 4 returns yield the last 4 link values in LIFO order. A 5th return uses target_i and pulses ras_underflow_o for 1 cycle.
- redirect_i with target 0x402 -> pc_o = TRAP_VECTOR, misaligned_o = 1 for 1 cycle, RAS count unchanged. trap_i together with redirect_i and stall_i -> pc_o = TRAP_VECTOR.
- Assert rst_n low asynchronously mid-cycle after 2 pushes -> pc_o = RESET_VECTOR immediately, ras_empty_o = 1. A following ret pulses ras_underflow_o.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

   // Next-PC source, listed in priority order (highest first).
   typedef enum logic [2:0] {
      SRC_TRAP,
      SRC_MISALIGN,
      SRC_RAS,
      SRC_TARGET,
      SRC_HOLD,
      SRC_SEQ
   } pc_src_e;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0004;

   // Widest address the alignment helper accepts; callers zero-extend.
   localparam int ADDR_MAX = 64;

   // True when addr has any bit set below the instruction-size boundary.
   function automatic logic is_misaligned(input logic [ADDR_MAX-1:0] addr,
                                          input int unsigned         instr_bytes);
      logic [ADDR_MAX-1:0] mask;
      mask = ADDR_MAX'(instr_bytes) - ADDR_MAX'(1);
      return (addr & mask) != '0;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top, with overwrite-oldest on full.
module pc_ras
   import pc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [RAS_DEPTH-1:0][XLEN-1:0] stack;
   logic [PW-1:0]                  ptr;      // next free slot; top lives one below
   logic [PW-1:0]                  top_idx;
   logic [CW-1:0]                  cnt;

   assign top_idx = ptr - PW'(1);
   assign top_o   = stack[top_idx];
   assign empty_o = (cnt == '0);
   assign full_o  = (cnt == CW'(RAS_DEPTH));

   // Stack update; push+pop on a non-empty stack swaps the top in place,
   // push+pop on an empty stack degenerates to a plain push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stack <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else if (push_i && pop_i && !empty_o) begin
         stack[top_idx] <= wdata_i;
      end else if (push_i) begin
         // When full, slot ptr holds the oldest entry, so it is simply overwritten.
         stack[ptr] <= wdata_i;
         ptr        <= ptr + PW'(1);
         if (!full_o) cnt <= cnt + CW'(1);
      end else if (pop_i && !empty_o) begin
         ptr <= ptr - PW'(1);
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, sequential adder, next-PC priority mux,
// return-address stack and the misalign/underflow pulse registers.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                  XLEN         = 32,
   parameter int unsigned         INSTR_BYTES  = 4,
   parameter logic [XLEN-1:0]     RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0]     TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
   parameter int                  RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] target_i,
   input  logic            call_i,
   input  logic            ret_i,
   input  logic            trap_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_o,
   output logic [XLEN-1:0] pc_next_o,
   output logic            ras_empty_o,
   output logic            ras_full_o,
   output logic            ras_underflow_o,
   output logic            misaligned_o
);

   pc_src_e         src;
   logic            tgt_mis;
   logic            ras_push;
   logic            ras_pop;
   logic [XLEN-1:0] ras_top;

   assign pc_plus_o = pc_o + XLEN'(INSTR_BYTES);
   assign tgt_mis   = is_misaligned(ADDR_MAX'(target_i), INSTR_BYTES);

   // Pick the next-PC source by fixed priority; stall only blocks sequential advance.
   always_comb begin
      src = SRC_SEQ;
      if (trap_i)                                src = SRC_TRAP;
      else if (redirect_i && tgt_mis)            src = SRC_MISALIGN;
      else if (redirect_i && ret_i && !ras_empty_o) src = SRC_RAS;
      else if (redirect_i)                       src = SRC_TARGET;
      else if (stall_i)                          src = SRC_HOLD;
   end

   // Map the chosen source onto an address.
   always_comb begin
      pc_next_o = pc_plus_o;
      unique case (src)
         SRC_TRAP, SRC_MISALIGN: pc_next_o = TRAP_VECTOR;
         SRC_RAS:                pc_next_o = ras_top;
         SRC_TARGET:             pc_next_o = target_i;
         SRC_HOLD:               pc_next_o = pc_o;
         default:                pc_next_o = pc_plus_o;
      endcase
   end

   // Stack activity only on accepted, aligned redirects.
   assign ras_push = (src inside {SRC_RAS, SRC_TARGET}) && call_i;
   assign ras_pop  = (src inside {SRC_RAS, SRC_TARGET}) && ret_i;

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .wdata_i (pc_plus_o),
      .top_o   (ras_top),
      .empty_o (ras_empty_o),
      .full_o  (ras_full_o)
   );

   // PC register plus one-cycle pulses; a return that lands on SRC_TARGET
   // can only mean the stack was empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_o            <= RESET_VECTOR;
         ras_underflow_o <= 1'b0;
         misaligned_o    <= 1'b0;
      end else begin
         pc_o            <= pc_next_o;
         ras_underflow_o <= (src == SRC_TARGET) && ret_i;
         misaligned_o    <= (src == SRC_MISALIGN);
      end
   end

endmodule
